// File: rtl/nios32_pio_pkg.sv
// rtl/nios32_pio_pkg.sv - shared register map and edge-select codes for nios32 PIO blocks
// Purpose: constants shared by the button PIO top and its bench.
// Contents: register addresses (DATA, IRQ_MASK, EDGE_CAP) and EDGE_TYPE codes.
package nios32_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios32_button_pio_irq_if.sv
// rtl/nios32_button_pio_irq_if.sv - Avalon-MM slave bus bundle for the button PIO
// Purpose: groups the register bus and interrupt line of the button PIO.
// Signals: address[1:0], chipselect, write, writedata[31:0] (master -> slave);
//          readdata[31:0], irq (slave -> master).
interface nios32_button_pio_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios32_button_debounce.sv
// rtl/nios32_button_debounce.sv - one-bit synchroniser and debouncer
// Purpose: brings one raw button input into the clock domain and filters bounce.
// Ports: clk, reset (async, active-high), raw (asynchronous input),
//        debounced (changes only after DEBOUNCE_CYCLES stable synchronised clocks).
module nios32_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic debounced
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      cnt       <= '0;
      debounced <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      // Any cycle agreeing with the current output restarts the stability count,
      // so a glitch shorter than the window never reaches the output.
      if (sync == debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        debounced <= sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nios32_button_pio_irq.sv
// rtl/nios32_button_pio_irq.sv - debounced button input port with edge capture and irq
// Purpose: WIDTH-bit Avalon-MM input slave; per-bit debounce, edge capture (W1C),
//          interrupt mask and level irq.
// Ports: clk, reset (async, active-high), bus (slave modport: address, chipselect,
//        write, writedata, readdata, irq), in_port[WIDTH-1:0] (raw button inputs).
module nios32_button_pio_irq
  import nios32_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = EDGE_FALLING
) (
  input logic                   clk,
  input logic                   reset,
  nios32_button_pio_irq_if.slave bus,
  input logic [WIDTH-1:0]       in_port
);

  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] clear;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios32_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .raw       (in_port[i]),
      .debounced (debounced[i])
    );
  end

  always_comb begin
    edges = '0;
    if (EDGE_TYPE == EDGE_RISING) begin
      edges = debounced & ~debounced_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edges = ~debounced & debounced_d;
    end else begin
      edges = debounced ^ debounced_d;
    end
  end

  assign wr_mask = bus.chipselect & bus.write & (bus.address == ADDR_MASK);
  assign wr_edge = bus.chipselect & bus.write & (bus.address == ADDR_EDGE);
  assign clear   = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

  // A new edge is ORed in after the clear so a coincident capture survives.
  assign edge_next = (edge_cap & ~clear) | edges;
  assign mask_next = wr_mask ? bus.writedata[WIDTH-1:0] : irq_mask;

  // Upper writedata bits have no storage behind them.
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced_d  <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      bus.irq      <= 1'b0;
      bus.readdata <= '0;
    end else begin
      debounced_d <= debounced;
      irq_mask    <= mask_next;
      edge_cap    <= edge_next;
      // irq is registered from the next-state values so it rises in the same
      // cycle the captured bit becomes readable.
      bus.irq     <= |(edge_next & mask_next);
      case (bus.address)
        ADDR_DATA: bus.readdata <= 32'(debounced);
        ADDR_MASK: bus.readdata <= 32'(irq_mask);
        ADDR_EDGE: bus.readdata <= 32'(edge_cap);
        default:   bus.readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios32_button_pio_irq.sv
// tb/tb_nios32_button_pio_irq.sv - scoreboard bench for nios32_button_pio_irq
module tb_nios32_button_pio_irq;

  localparam int DC = 16;
  localparam int HL = DC + 2;

  typedef struct packed {
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;
  } exp_t;

  logic        clk = 1'b0;
  logic        t_rst = 1'b1;
  logic [1:0]  t_addr = '0;
  logic        t_cs = 1'b0;
  logic        t_wr = 1'b0;
  logic [31:0] t_wd = '0;
  logic [7:0]  t_in = '0;

  logic        p_rst;
  logic [1:0]  p_addr;
  logic        p_cs;
  logic        p_wr;
  logic [31:0] p_wd;
  logic [7:0]  p_in;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];

  logic [31:0] m_hist [2][HL];
  logic [31:0] m_deb  [2];
  logic [31:0] m_last [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_ecap [2];
  logic [31:0] m_rd   [2];
  logic        m_irq  [2];
  logic [31:0] wm     [2];
  int          et     [2];

  always #5 clk = ~clk;

  nios32_button_pio_irq_if ifa ();
  nios32_button_pio_irq_if ifb ();

  assign ifa.address    = t_addr;
  assign ifa.chipselect = t_cs;
  assign ifa.write      = t_wr;
  assign ifa.writedata  = t_wd;
  assign ifb.address    = t_addr;
  assign ifb.chipselect = t_cs;
  assign ifb.write      = t_wr;
  assign ifb.writedata  = t_wd;

  nios32_button_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) dut_a (
    .clk(clk), .reset(t_rst), .bus(ifa), .in_port(t_in[3:0])
  );

  nios32_button_pio_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(t_rst), .bus(ifb), .in_port(t_in)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < HL; i++) m_hist[d][i] = '0;
      m_deb[d]  = '0;
      m_last[d] = '0;
      m_mask[d] = '0;
      m_ecap[d] = '0;
      m_rd[d]   = '0;
      m_irq[d]  = 1'b0;
    end
  endtask

  // Reference: a bit's debounced value takes a new level once the last DC
  // synchronised samples (input history delayed by two clocks) all show it;
  // the capture register sees that change one clock later.
  task automatic model_edge();
    logic [31:0] ones, zeros, flip, ev;
    for (int d = 0; d < 2; d++) begin
      if (!t_rst) begin
        case (t_addr)
          2'd0:    m_rd[d] = m_deb[d];
          2'd2:    m_rd[d] = m_mask[d];
          2'd3:    m_rd[d] = m_ecap[d];
          default: m_rd[d] = '0;
        endcase
        for (int i = HL - 1; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
        m_hist[d][0] = {24'b0, t_in} & wm[d];
        ones  = wm[d];
        zeros = wm[d];
        for (int i = 2; i < HL; i++) begin
          ones  = ones & m_hist[d][i];
          zeros = zeros & ~m_hist[d][i];
        end
        flip = (~m_deb[d] & ones) | (m_deb[d] & zeros);
        if (et[d] == 0)      ev = m_last[d] & m_deb[d];
        else if (et[d] == 1) ev = m_last[d] & ~m_deb[d];
        else                 ev = m_last[d];
        if (t_cs && t_wr && t_addr == 2'd3) m_ecap[d] = m_ecap[d] & ~t_wd;
        m_ecap[d] = (m_ecap[d] | ev) & wm[d];
        if (t_cs && t_wr && t_addr == 2'd2) m_mask[d] = t_wd & wm[d];
        m_irq[d]  = |(m_ecap[d] & m_mask[d]);
        m_deb[d]  = m_deb[d] ^ flip;
        m_last[d] = flip;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    t_rst  = p_rst;
    t_addr = p_addr;
    t_cs   = p_cs;
    t_wr   = p_wr;
    t_wd   = p_wd;
    t_in   = p_in;
    if (t_rst) model_reset();
    e.rd_a  = m_rd[0];
    e.rd_b  = m_rd[1];
    e.irq_a = m_irq[0];
    e.irq_b = m_irq[1];
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    p_addr = a;
    p_cs   = 1'b1;
    p_wr   = 1'b1;
    p_wd   = d;
    tick();
    p_cs   = 1'b0;
    p_wr   = 1'b0;
    p_wd   = $urandom();
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks = checks + 4;
        if (ifa.readdata !== e.rd_a) begin
          failures++;
          $display("FAIL rd_a t=%0t got=%h exp=%h", $time, ifa.readdata, e.rd_a);
        end
        if (ifb.readdata !== e.rd_b) begin
          failures++;
          $display("FAIL rd_b t=%0t got=%h exp=%h", $time, ifb.readdata, e.rd_b);
        end
        if (ifa.irq !== e.irq_a) begin
          failures++;
          $display("FAIL irq_a t=%0t got=%b exp=%b", $time, ifa.irq, e.irq_a);
        end
        if (ifb.irq !== e.irq_b) begin
          failures++;
          $display("FAIL irq_b t=%0t got=%b exp=%b", $time, ifb.irq, e.irq_b);
        end
      end
    end
  end

  initial begin
    wm[0] = 32'h0000_000F;
    wm[1] = 32'h0000_00FF;
    et[0] = 1;
    et[1] = 2;
    model_reset();
    p_rst = 1'b1; p_addr = '0; p_cs = 1'b0; p_wr = 1'b0; p_wd = '0; p_in = 8'h00;
    hold(3);

    // Inputs high across reset release, then a short glitch on bit0.
    p_in = 8'h0F;
    hold(2);
    p_rst = 1'b0;
    hold(25);
    p_in = 8'h0E;
    hold(10);
    p_in = 8'h0F;
    hold(25);
    p_addr = 2'd3;
    hold(3);

    // Falling edge on bit1 with mask 2, then W1C.
    wr_reg(2'd2, 32'h2);
    p_addr = 2'd3;
    p_in = 8'h0D;
    hold(25);
    wr_reg(2'd3, 32'h2);
    p_addr = 2'd3;
    hold(3);
    p_in = 8'h0F;
    hold(25);
    wr_reg(2'd3, 32'hFF);

    // Edge on bit3 while masked off, then unmask.
    wr_reg(2'd2, 32'h0);
    p_addr = 2'd3;
    p_in = 8'h07;
    hold(25);
    wr_reg(2'd2, 32'h8);
    p_addr = 2'd3;
    hold(3);
    wr_reg(2'd3, 32'h8);
    p_in = 8'h0F;
    hold(25);
    wr_reg(2'd3, 32'hFF);

    // W1C of bit2 landing on the clock its capture sets.
    p_in = 8'h0B;
    hold(DC + 2);
    wr_reg(2'd3, 32'h4);
    p_addr = 2'd3;
    hold(3);
    p_in = 8'h0F;
    hold(25);
    wr_reg(2'd3, 32'hFF);

    // Bit7 up and down with clears between; oversized mask write.
    p_in = 8'h8F;
    hold(25);
    p_addr = 2'd3;
    hold(2);
    wr_reg(2'd3, 32'hFF);
    p_in = 8'h0F;
    hold(25);
    p_addr = 2'd3;
    hold(2);
    wr_reg(2'd2, 32'hFFFF_FF00);
    p_addr = 2'd2;
    hold(3);

    // Reset in the middle of pending captures and an active mask.
    wr_reg(2'd2, 32'hFF);
    p_in = 8'h00;
    hold(22);
    p_addr = 2'd3;
    p_rst = 1'b1;
    hold(2);
    p_rst = 1'b0;
    hold(2);
    p_addr = 2'd2;
    hold(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      p_addr = 2'($urandom_range(0, 3));
      p_cs   = ($urandom_range(0, 9) == 0);
      p_wr   = p_cs && ($urandom_range(0, 1) == 1);
      p_wd   = $urandom();
      if ($urandom_range(0, 29) == 0) p_in = p_in ^ 8'(1 << $urandom_range(0, 7));
      p_rst  = ($urandom_range(0, 999) == 0);
      tick();
    end
    p_rst = 1'b0;
    p_cs  = 1'b0;
    p_wr  = 1'b0;
    hold(2);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
